// File: rtl/generic_phase_fifo_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : generic_phase_fifo_seq_checker
//  Description : Read-side sequence checker for the 2-clock phase-compensation
//                FIFO. It hunts for an incrementing counter on rddata and
//                declares lock. While locked it flags and counts corrupted or
//                slipped words.
//  Options     : PHASE_FIFO_SEQ_CHK_ERR_CNT_EN - when defined, builds the
//                saturating err_cnt and the clr_cnt logic. When undefined,
//                err_cnt reads 0 and clr_cnt is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module generic_phase_fifo_seq_checker #(
    parameter int DW         = 20,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ECW        = 16
) (
    input  logic           clk,
    input  logic           sreset,
    input  logic [DW-1:0]  rddata,
    input  logic           chk_en,
    input  logic           clr_cnt,
    output logic           locked,
    output logic           err_pulse,
    output logic [ECW-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Counter values at which the next match / miss causes a state change
    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

    state_t          state;
    logic [DW-1:0]   exp_r;
    logic [3:0]      match_cnt;
    logic [3:0]      miss_cnt;

    logic            match;
    logic            err_event;
    logic [DW-1:0]   rddata_inc;

    // Mod-2^DW successor arithmetic, so all-ones followed by zero matches
    assign rddata_inc = rddata + DW'(1);
    assign match      = (rddata == exp_r);
    // Only a miss while actively locked counts as an error
    assign err_event  = chk_en && (state == ST_LOCKED) && !match;

    // Hunt / lock state machine with registered locked and err_pulse
    always_ff @(posedge clk) begin
        if (sreset) begin
            state     <= ST_IDLE;
            exp_r     <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else if (!chk_en) begin
            // Disabled: park in IDLE and keep seeding from the live data
            state     <= ST_IDLE;
            exp_r     <= rddata_inc;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_HUNT;
                    exp_r     <= rddata_inc;
                    match_cnt <= '0;
                    miss_cnt  <= '0;
                    locked    <= 1'b0;
                    err_pulse <= 1'b0;
                end
                ST_HUNT: begin
                    // Reseed every cycle; count consecutive successor words
                    exp_r     <= rddata_inc;
                    err_pulse <= 1'b0;
                    if (match) begin
                        match_cnt <= match_cnt + 4'd1;
                        if (match_cnt == LOCK_LAST) begin
                            state    <= ST_LOCKED;
                            miss_cnt <= '0;
                            locked   <= 1'b1;
                        end else begin
                            locked   <= 1'b0;
                        end
                    end else begin
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    // Free-running expectation; a slip shows up as a miss run
                    exp_r <= exp_r + DW'(1);
                    if (match) begin
                        miss_cnt  <= '0;
                        err_pulse <= 1'b0;
                        locked    <= 1'b1;
                    end else begin
                        err_pulse <= 1'b1;
                        miss_cnt  <= miss_cnt + 4'd1;
                        if (miss_cnt == UNLOCK_LAST) begin
                            state     <= ST_HUNT;
                            match_cnt <= '0;
                            exp_r     <= rddata_inc;
                            locked    <= 1'b0;
                        end else begin
                            locked    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    locked    <= 1'b0;
                    err_pulse <= 1'b0;
                end
            endcase
        end
    end

`ifdef PHASE_FIFO_SEQ_CHK_ERR_CNT_EN
    // Saturating error counter; a coincident clear wins over a new error
    always_ff @(posedge clk) begin
        if (sreset) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (err_event && (err_cnt != {ECW{1'b1}})) begin
            err_cnt <= err_cnt + ECW'(1);
        end
    end
`else
    logic unused_err_inputs;
    assign unused_err_inputs = clr_cnt ^ err_event;
    assign err_cnt           = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_generic_phase_fifo_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_generic_phase_fifo_seq_checker
//  Description : Self-checking bench: a hand-derived vector table, directed
//                corner sequences and randomized traffic against a run-length
//                reference model. A second instance uses ECW=2 to exercise
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_phase_fifo_seq_checker;

    localparam int DW         = 20;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 3;
    localparam int CMAX       = 65535;
    localparam int CMAX2      = 3;
`ifdef PHASE_FIFO_SEQ_CHK_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sreset;
    logic [DW-1:0] rddata;
    logic          chk_en;
    logic          clr_cnt;
    logic          locked,  err_pulse;
    logic [15:0]   err_cnt;
    logic          locked2, err_pulse2;
    logic [1:0]    err_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generic_phase_fifo_seq_checker #(
        .DW(DW), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ECW(16)
    ) dut (
        .clk(clk), .sreset(sreset), .rddata(rddata), .chk_en(chk_en),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt)
    );

    generic_phase_fifo_seq_checker #(
        .DW(DW), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ECW(2)
    ) dut2 (
        .clk(clk), .sreset(sreset), .rddata(rddata), .chk_en(chk_en),
        .clr_cnt(clr_cnt), .locked(locked2), .err_pulse(err_pulse2),
        .err_cnt(err_cnt2)
    );

    // ---------------- reference model (run-length view) ----------------
    localparam int M_IDLE = 0, M_HUNT = 1, M_LOCK = 2;
    int            m_mode = M_IDLE;
    logic [DW-1:0] m_prev = '0;
    logic [DW-1:0] m_expect = '0;
    int            m_run = 0, m_miss = 0, m_cnt = 0, m_cnt2 = 0;
    bit            m_pulse = 1'b0;

    function automatic void model_step(bit r, bit e, bit c, logic [DW-1:0] d);
        logic [DW-1:0] succ;
        succ = m_prev + 1;
        if (r) begin
            m_mode = M_IDLE; m_prev = '0; m_run = 0; m_miss = 0;
            m_pulse = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_pulse = 0;
            if (!e || m_mode == M_IDLE) begin
                m_mode = e ? M_HUNT : M_IDLE;
                m_run  = 0;
                m_miss = 0;
                m_prev = d;
            end else if (m_mode == M_HUNT) begin
                m_run  = (d == succ) ? m_run + 1 : 0;
                m_prev = d;
                if (m_run >= LOCK_CNT) begin
                    m_mode   = M_LOCK;
                    m_expect = d + 1;
                    m_miss   = 0;
                end
            end else begin
                if (d == m_expect) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    m_miss++;
                    if (m_cnt  < CMAX)  m_cnt++;
                    if (m_cnt2 < CMAX2) m_cnt2++;
                    if (m_miss >= UNLOCK_CNT) begin
                        m_mode = M_HUNT;
                        m_run  = 0;
                        m_prev = d;
                    end
                end
                m_expect = m_expect + 1;
            end
            if (c) begin
                m_cnt  = 0;
                m_cnt2 = 0;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive inputs away from the edge, let the model see the same edge, sample on negedge
    task automatic apply(input bit r, input bit e, input bit c, input logic [DW-1:0] d);
        sreset = r; chk_en = e; clr_cnt = c; rddata = d;
        @(posedge clk);
        model_step(r, e, c, d);
        @(negedge clk);
    endtask

    task automatic mchk(input string tag);
        check({tag, "_locked"},  longint'(locked),    longint'(m_mode == M_LOCK));
        check({tag, "_locked2"}, longint'(locked2),   longint'(m_mode == M_LOCK));
        check({tag, "_pulse"},   longint'(err_pulse), longint'(m_pulse));
        check({tag, "_cnt"},     longint'(err_cnt),   ERR_EN ? longint'(m_cnt)  : 0);
        check({tag, "_cnt2"},    longint'(err_cnt2),  ERR_EN ? longint'(m_cnt2) : 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            rst;
        bit            en;
        bit            clr;
        logic [DW-1:0] d;
        bit            lk;
        bit            pl;
        int            cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit r, bit e, bit c, logic [DW-1:0] d, bit lk, bit pl, int cnt);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.d = d; v.lk = lk; v.pl = pl; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    logic [DW-1:0] seq;

    task automatic good(input string tag);
        apply(1'b0, 1'b1, 1'b0, seq);
        seq = seq + 1;
        mchk(tag);
    endtask

    task automatic bad(input string tag, input bit c);
        logic [DW-1:0] corrupt;
        corrupt = seq ^ 20'h00100;
        apply(1'b0, 1'b1, c, corrupt);
        seq = seq + 1;
        mchk(tag);
    endtask

    initial begin
        sreset = 1'b1; chk_en = 1'b0; clr_cnt = 1'b0; rddata = '0;

        // Reset, lock on 0x10.., one corrupted word, then a lone clear
        add(1, 1, 0, 20'h00000, 0, 0, 0);
        add(1, 1, 0, 20'h00000, 0, 0, 0);
        add(0, 1, 0, 20'h00010, 0, 0, 0);
        add(0, 1, 0, 20'h00011, 0, 0, 0);
        add(0, 1, 0, 20'h00012, 0, 0, 0);
        add(0, 1, 0, 20'h00013, 0, 0, 0);
        add(0, 1, 0, 20'h00014, 1, 0, 0);
        for (int k = 'h15; k <= 'h1F; k++) add(0, 1, 0, DW'(k), 1, 0, 0);
        add(0, 1, 0, 20'h00055, 1, 1, 1);
        add(0, 1, 0, 20'h00021, 1, 0, 1);
        add(0, 1, 0, 20'h00022, 1, 0, 1);
        add(0, 1, 1, 20'h00023, 1, 0, 0);
        add(0, 1, 0, 20'h00024, 1, 0, 0);

        @(negedge clk);
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].d);
            check($sformatf("tbl%0d_locked", i), longint'(locked),    longint'(tbl[i].lk));
            check($sformatf("tbl%0d_pulse", i),  longint'(err_pulse), longint'(tbl[i].pl));
            check($sformatf("tbl%0d_cnt", i),    longint'(err_cnt),   ERR_EN ? longint'(tbl[i].cnt) : 0);
            check($sformatf("tbl%0d_cnt2", i),   longint'(err_cnt2),  ERR_EN ? longint'(tbl[i].cnt) : 0);
        end

        // Wrap across all-ones -> zero while locked
        apply(1'b1, 1'b1, 1'b0, '0);
        mchk("wrap_rst");
        seq = 20'hFFFF8;
        for (int k = 0; k < 12; k++) good("wrap");
        check("wrap_end_locked", longint'(locked), 1);
        check("wrap_end_pulse",  longint'(err_pulse), 0);
        check("wrap_end_cnt",    longint'(err_cnt), 0);

        // Slip by +8: three misses drop lock, four new words relock
        good("slip_pre");
        seq = seq + 8;
        bad_slip: begin
            apply(1'b0, 1'b1, 1'b0, seq); seq = seq + 1; mchk("slip_m1");
            apply(1'b0, 1'b1, 1'b0, seq); seq = seq + 1; mchk("slip_m2");
            check("slip_m2_locked", longint'(locked), 1);
            apply(1'b0, 1'b1, 1'b0, seq); seq = seq + 1; mchk("slip_m3");
            check("slip_m3_locked", longint'(locked), 0);
            check("slip_m3_cnt",    longint'(err_cnt), ERR_EN ? 3 : 0);
            check("slip_m3_pulse",  longint'(err_pulse), 1);
        end
        for (int k = 0; k < 3; k++) good("relock");
        check("relock3_locked", longint'(locked), 0);
        good("relock");
        check("relock4_locked", longint'(locked), 1);

        // Saturation on the ECW=2 instance, then clear coincident with an error
        apply(1'b0, 1'b1, 1'b1, seq); seq = seq + 1; mchk("sat_clr0");
        for (int k = 0; k < 5; k++) begin
            bad("sat_err", 1'b0);
            good("sat_gap");
            good("sat_gap");
        end
        check("sat_cnt2", longint'(err_cnt2), ERR_EN ? 3 : 0);
        check("sat_cnt",  longint'(err_cnt),  ERR_EN ? 5 : 0);
        bad("sat_clr_err", 1'b1);
        check("clr_err_cnt",   longint'(err_cnt),   0);
        check("clr_err_cnt2",  longint'(err_cnt2),  0);
        check("clr_err_pulse", longint'(err_pulse), 1);
        good("sat_post");

        // chk_en dropped for one cycle: lock drops, count held, relock after 5 words
        bad("en_err", 1'b0);
        good("en_pre");
        apply(1'b0, 1'b0, 1'b0, seq); seq = seq + 1; mchk("en_off");
        check("en_off_locked", longint'(locked), 0);
        check("en_off_cnt",    longint'(err_cnt), ERR_EN ? 1 : 0);
        for (int k = 0; k < 4; k++) good("en_relock");
        check("en_relock4_locked", longint'(locked), 0);
        good("en_relock");
        check("en_relock5_locked", longint'(locked), 1);

        // Randomized traffic: corruption, slips, enable drops, clears, resets
        seq = 20'hFFC00;
        for (int n = 0; n < 3000; n++) begin
            int            r;
            bit            rs, en, cl;
            logic [DW-1:0] d;
            r  = int'($urandom_range(0, 199));
            rs = (r == 0);
            en = !(r >= 1 && r <= 4);
            cl = (r >= 5 && r <= 8);
            d  = seq;
            if (r >= 9 && r <= 18) d = seq ^ DW'(1 << $urandom_range(0, DW - 1));
            if (r >= 19 && r <= 21) begin
                seq = seq + DW'($urandom_range(2, 20));
                d   = seq;
            end
            apply(rs, en, cl, d);
            seq = seq + 1;
            mchk("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
